// File: rtl/mem_stream_mux.sv
// mem_stream_mux
// ----------------------------------------------------------------------------
// Parametrised N-channel memory-to-stream multiplexer. For every bunch
// crossing (BX) it emits a header word, then drains the memory channels that
// report data in round-robin order, then (optionally) emits a trailer word.
// The result is a single registered valid/ready stream to the link serialiser.
//
// Optional feature macro: MEM_STREAM_TRAILER_EN
//   defined   : a trailer word {mark, 1, truncated, bx, count, 0...} closes
//               each BX.
//   undefined : the readout returns straight to IDLE after the data phase.
//               The per-BX word limit still applies, silently.
//
// Ports:
//   clk         clock
//   rst_n       asynchronous active-low reset
//   bx_start    one-cycle pulse, begin readout of the BX given on bx
//   bx          BX number, captured when bx_start is accepted
//   in_valid    per-channel data-available flags
//   in_dat      flattened channel data, channel k at [k*DAT_W +: DAT_W]
//   in_rd       one-hot pop strobe to the source memories (combinational)
//   out_ready   downstream accept
//   out_valid   output word valid
//   out_dat     {code, payload}; code k+1 = channel k, all-ones = header/trailer
//   busy        readout FSM is not IDLE
//   bx_overlap  one-cycle pulse: a bx_start was dropped
//
// Handshake: a word is transferred on a clock edge where out_valid and
// out_ready are both high. The output register advances (adv) when it is
// empty or being accepted; while it does not advance, out_valid/out_dat hold
// and no channel is popped.
// ----------------------------------------------------------------------------
module mem_stream_mux #(
    parameter int N_CH      = 12,
    parameter int DAT_W     = 44,
    parameter int BX_W      = 3,
    parameter int SEL_W     = 4,
    parameter int CNT_W     = 8,
    parameter int MAX_WORDS = 108
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   bx_start,
    input  logic [BX_W-1:0]        bx,
    input  logic [N_CH-1:0]        in_valid,
    input  logic [N_CH*DAT_W-1:0]  in_dat,
    output logic [N_CH-1:0]        in_rd,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [SEL_W+DAT_W-1:0] out_dat,
    output logic                   busy,
    output logic                   bx_overlap
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        DATA    = 2'd2,
        TRAILER = 2'd3
    } state_t;

    localparam logic [SEL_W-1:0] CODE_MARK = '1;
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(MAX_WORDS - 1);
    localparam logic [SEL_W-1:0] LAST_CH   = SEL_W'(N_CH - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                   state,   state_n;
    logic [SEL_W-1:0]         rr,      rr_n;
    logic [CNT_W-1:0]         count,   count_n;
    logic [BX_W-1:0]          cur_bx,  cur_bx_n;
    logic                     pending, pending_n;
    logic [BX_W-1:0]          pend_bx, pend_bx_n;
    logic                     ov_n;
    logic [SEL_W+DAT_W-1:0]   od_n;
    logic                     overlap_n;
`ifdef MEM_STREAM_TRAILER_EN
    logic                     trunc,   trunc_n;
`endif

    logic                     adv;
    logic                     found;
    logic [SEL_W-1:0]         grant;
    logic [DAT_W-1:0]         ch_dat [N_CH];

    assign adv  = !out_valid || out_ready;
    assign busy = (state != IDLE);

    for (genvar k = 0; k < N_CH; k++) begin : g_split
        assign ch_dat[k] = in_dat[k*DAT_W +: DAT_W];
    end

    // Header payload: MSB 0, BX number just below it, rest zero.
    function automatic logic [DAT_W-1:0] hdr_payload(input logic [BX_W-1:0] b);
        logic [DAT_W-1:0] p;
        p = '0;
        p[DAT_W-2 -: BX_W] = b;
        return p;
    endfunction

`ifdef MEM_STREAM_TRAILER_EN
    // Trailer payload: MSB 1, truncated flag, BX number, word count, zeros.
    function automatic logic [DAT_W-1:0] trl_payload(input logic             t,
                                                     input logic [BX_W-1:0]  b,
                                                     input logic [CNT_W-1:0] c);
        logic [DAT_W-1:0] p;
        p = '0;
        p[DAT_W-1]                 = 1'b1;
        p[DAT_W-2]                 = t;
        p[DAT_W-3 -: BX_W]         = b;
        p[DAT_W-3-BX_W -: CNT_W]   = c;
        return p;
    endfunction
`endif

    // ------------------------------------------------------------------
    // Round-robin search: first valid channel at or above rr, wrapping.
    // ------------------------------------------------------------------
    always_comb begin
        logic [SEL_W:0] idx_w;
        found = 1'b0;
        grant = '0;
        idx_w = '0;
        for (int i = 0; i < N_CH; i++) begin
            idx_w = {1'b0, rr} + (SEL_W+1)'(i);
            if (idx_w >= (SEL_W+1)'(N_CH)) begin
                idx_w = idx_w - (SEL_W+1)'(N_CH);
            end
            if (!found && in_valid[idx_w[SEL_W-1:0]]) begin
                found = 1'b1;
                grant = idx_w[SEL_W-1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_n   = state;
        rr_n      = rr;
        count_n   = count;
        cur_bx_n  = cur_bx;
        pending_n = pending;
        pend_bx_n = pend_bx;
        ov_n      = out_valid;
        od_n      = out_dat;
        overlap_n = 1'b0;
        in_rd     = '0;
`ifdef MEM_STREAM_TRAILER_EN
        trunc_n   = trunc;
`endif

        // A request arriving while a readout is in progress (including the
        // cycle the FSM heads back to IDLE) is parked in the single pending
        // slot; a second one is dropped and flagged.
        if (bx_start && state != IDLE) begin
            if (!pending) begin
                pending_n = 1'b1;
                pend_bx_n = bx;
            end else begin
                overlap_n = 1'b1;
            end
        end

        case (state)
            IDLE: begin
                if (pending || bx_start) begin
                    cur_bx_n = pending ? pend_bx : bx;
                    if (pending) begin
                        // The parked BX starts now; a fresh request in the
                        // same cycle takes over the freed pending slot.
                        pending_n = bx_start;
                        if (bx_start) begin
                            pend_bx_n = bx;
                        end
                    end
                    // Load the header in the start cycle itself so it is on
                    // the output one cycle after bx_start; HEADER only
                    // exists to wait out a stalled output register.
                    if (adv) begin
                        ov_n    = 1'b1;
                        od_n    = {CODE_MARK, hdr_payload(cur_bx_n)};
                        state_n = DATA;
                    end else begin
                        state_n = HEADER;
                    end
                end else if (adv) begin
                    ov_n = 1'b0;
                end
            end

            HEADER: begin
                if (adv) begin
                    ov_n    = 1'b1;
                    od_n    = {CODE_MARK, hdr_payload(cur_bx)};
                    state_n = DATA;
                end
            end

            DATA: begin
                if (adv) begin
                    if (found) begin
                        in_rd[grant] = 1'b1;
                        ov_n         = 1'b1;
                        od_n         = {grant + 1'b1, ch_dat[grant]};
                        rr_n         = (grant == LAST_CH) ? '0 : grant + 1'b1;
                        count_n      = count + 1'b1;
                        if (count == LAST_CNT) begin
`ifdef MEM_STREAM_TRAILER_EN
                            trunc_n = 1'b1;
                            state_n = TRAILER;
`else
                            state_n = IDLE;
                            count_n = '0;
`endif
                        end
                    end else begin
                        ov_n = 1'b0;
`ifdef MEM_STREAM_TRAILER_EN
                        state_n = TRAILER;
`else
                        state_n = IDLE;
                        count_n = '0;
`endif
                    end
                end
            end

`ifdef MEM_STREAM_TRAILER_EN
            TRAILER: begin
                if (adv) begin
                    ov_n    = 1'b1;
                    od_n    = {CODE_MARK, trl_payload(trunc, cur_bx, count)};
                    state_n = IDLE;
                    count_n = '0;
                    trunc_n = 1'b0;
                end
            end
`endif

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rr         <= '0;
            count      <= '0;
            cur_bx     <= '0;
            pending    <= 1'b0;
            pend_bx    <= '0;
            out_valid  <= 1'b0;
            out_dat    <= '0;
            bx_overlap <= 1'b0;
`ifdef MEM_STREAM_TRAILER_EN
            trunc      <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            rr         <= rr_n;
            count      <= count_n;
            cur_bx     <= cur_bx_n;
            pending    <= pending_n;
            pend_bx    <= pend_bx_n;
            out_valid  <= ov_n;
            out_dat    <= od_n;
            bx_overlap <= overlap_n;
`ifdef MEM_STREAM_TRAILER_EN
            trunc      <= trunc_n;
`endif
        end
    end

endmodule
